// File: rtl/veryl_testcase_module04_arbiter.sv
// Round-robin arbiter sharing one data port among N valid/last burst requesters.
// Define VERYL_TESTCASE_ARB_HOLD_LIMIT_EN to cap accepted beats per grant at MAX_HOLD.
module veryl_testcase_module04_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N-1:0]           i_req,
  input  logic [N*WIDTH-1:0]     i_data,
  input  logic [N-1:0]           i_last,
  input  logic                   i_ready,
  output logic [N-1:0]           o_gnt,
  output logic [$clog2(N)-1:0]   o_owner,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_last
);

  localparam int unsigned OW = $clog2(N);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          r_state, w_state_d;
  logic [OW-1:0]   r_owner, w_owner_d;
  logic [OW-1:0]   r_ptr, w_ptr_d;
  logic [N-1:0]    r_gnt, w_gnt_d;

  logic [WIDTH-1:0] w_data_arr [N];
  logic             w_own_req, w_own_last, w_valid, w_accept, w_release, w_hold_hit;
  logic             w_found;
  logic [OW-1:0]    w_pick;
  int unsigned      w_k;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_data_arr[g] = i_data[g*WIDTH +: WIDTH];
  end

  assign w_own_req  = i_req[r_owner];
  assign w_own_last = i_last[r_owner];
  assign w_valid    = (r_state == StBusy) && w_own_req;
  assign w_accept   = w_valid && i_ready;
  // Withdrawal releases without transferring a beat, so it need not wait for i_ready.
  assign w_release  = !w_own_req || (w_accept && (w_own_last || w_hold_hit));

  // First requester after the last owner, wrapping N-1 -> 0.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_k     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_k = (32'(r_ptr) + i) % N;
      if (!w_found && i_req[OW'(w_k)]) begin
        w_found = 1'b1;
        w_pick  = OW'(w_k);
      end
    end
  end

`ifdef VERYL_TESTCASE_ARB_HOLD_LIMIT_EN
  logic [7:0] r_cnt, w_cnt_d;

  assign w_hold_hit = w_accept && (r_cnt == 8'(MAX_HOLD - 1));

  always_comb begin
    w_cnt_d = r_cnt;
    if (r_state == StIdle && w_found) begin
      w_cnt_d = '0;
    end else if (w_accept) begin
      w_cnt_d = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end
`else
  // No beat counter; MAX_HOLD is never 0, so this term is constant false.
  assign w_hold_hit = (MAX_HOLD == 0) && w_accept;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_owner <= '0;
      r_ptr   <= OW'(N - 1);
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_owner <= w_owner_d;
      r_ptr   <= w_ptr_d;
      r_gnt   <= w_gnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_ptr_d   = r_ptr;
    w_gnt_d   = r_gnt;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d = StBusy;
          w_owner_d = w_pick;
          w_gnt_d   = {{(N-1){1'b0}}, 1'b1} << w_pick;
        end
      end
      StBusy: begin
        if (w_release) begin
          w_state_d = StIdle;
          w_ptr_d   = r_owner;
          w_gnt_d   = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_gnt   = r_gnt;
    o_owner = r_owner;
    o_busy  = (r_state == StBusy);
    o_valid = w_valid;
    o_data  = (r_state == StBusy) ? w_data_arr[r_owner] : '0;
    o_last  = w_valid && w_own_last;
  end

endmodule

// File: tb/tb_veryl_testcase_module04_arbiter.sv
// Directed bench for veryl_testcase_module04_arbiter; inputs driven and outputs checked mid-cycle.
module tb_veryl_testcase_module04_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic [3:0]  i_req;
  logic [3:0]  i_last;
  logic        i_ready;
  logic [9:0]  d [4];
  logic [39:0] w_data;
  logic [3:0]  o_gnt;
  logic [1:0]  o_owner;
  logic        o_busy;
  logic        o_valid;
  logic [9:0]  o_data;
  logic        o_last;

  int errors = 0;
  int checks = 0;

  assign w_data = {d[3], d[2], d[1], d[0]};

  veryl_testcase_module04_arbiter #(
    .N        (4),
    .WIDTH    (10),
    .MAX_HOLD (2)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_req),
    .i_data  (w_data),
    .i_last  (i_last),
    .i_ready (i_ready),
    .o_gnt   (o_gnt),
    .o_owner (o_owner),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge i_clk);
  endtask

  // Leaves reset released at a negedge with all inputs idle.
  task automatic do_reset();
    cyc();
    i_rst_n = 1'b0;
    i_req = '0; i_last = '0; i_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    cyc();
    i_rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_t1 [7];
    logic [3:0] exp_t2 [9];
    exp_t1 = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0100};
    exp_t2 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000,
               4'b0001};

    i_rst_n = 1'b0;
    i_req = '0; i_last = '0; i_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    #2;
    check("rst_gnt", 32'(o_gnt), 0);
    check("rst_owner", 32'(o_owner), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_last", 32'(o_last), 0);

    // Requesters 0 and 2, single-beat bursts.
    do_reset();
    i_req = 4'b0101; i_last = 4'b0101; i_ready = 1'b1;
    d[0] = 10'h0AA; d[2] = 10'h155;
    for (int i = 0; i < 7; i++) begin
      cyc(); #1;
      check($sformatf("t1_gnt%0d", i), 32'(o_gnt), 32'(exp_t1[i]));
      if (i == 0) check("t1_data0", 32'(o_data), 32'h0AA);
      if (i == 2) check("t1_data2", 32'(o_data), 32'h155);
      if (i == 2) check("t1_owner2", 32'(o_owner), 2);
    end

    // All four, single-beat bursts.
    do_reset();
    i_req = 4'b1111; i_last = 4'b1111; i_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc(); #1;
      check($sformatf("t2_gnt%0d", i), 32'(o_gnt), 32'(exp_t2[i]));
    end

    // Requester 1, 3-beat burst with ready stalls.
    do_reset();
    i_req = 4'b0010; i_last = 4'b0000; i_ready = 1'b1; d[1] = 10'h001;
    #1 check("t3_idle", 32'(o_busy), 0);
    cyc(); i_ready = 1'b0; #1;
    check("t3_gnt", 32'(o_gnt), 32'b0010);
    check("t3_v1", 32'(o_valid), 1);
    check("t3_d1_stall", 32'(o_data), 32'h001);
    cyc(); i_ready = 1'b1; #1;
    check("t3_d1_acc", 32'(o_data), 32'h001);
    check("t3_l1", 32'(o_last), 0);
    cyc(); d[1] = 10'h002; #1;
    check("t3_d2_acc", 32'(o_data), 32'h002);
    check("t3_busy2", 32'(o_busy), 1);
    cyc(); d[1] = 10'h3FF; i_last = 4'b0010; i_ready = 1'b0; #1;
    check("t3_d3_stall", 32'(o_data), 32'h3FF);
    check("t3_l3_stall", 32'(o_last), 1);
    cyc(); i_ready = 1'b1; #1;
    check("t3_busy3", 32'(o_busy), 1);
    check("t3_d3_acc", 32'(o_data), 32'h3FF);
    cyc(); i_req = '0; #1;
    check("t3_rel_busy", 32'(o_busy), 0);
    check("t3_rel_gnt", 32'(o_gnt), 0);
    check("t3_rel_data", 32'(o_data), 0);

    // Owner 2 withdraws after one beat; 3 pending, 0 joins late.
    do_reset();
    i_req = 4'b1100; i_last = 4'b0000; i_ready = 1'b1; d[2] = 10'h077;
    cyc(); #1;
    check("t4_gnt", 32'(o_gnt), 32'b0100);
    check("t4_valid", 32'(o_valid), 1);
    cyc(); i_req = 4'b1001; #1;
    check("t4_wd_busy", 32'(o_busy), 1);
    check("t4_wd_valid", 32'(o_valid), 0);
    cyc(); #1;
    check("t4_rel_busy", 32'(o_busy), 0);
    cyc(); #1;
    check("t4_next_gnt", 32'(o_gnt), 32'b1000);
    check("t4_next_owner", 32'(o_owner), 3);

    // Requester 0 5-beat burst with requester 1 pending.
    do_reset();
    i_req = 4'b0011; i_last = 4'b0010; i_ready = 1'b1; d[0] = 10'd1; d[1] = 10'h211;
    cyc(); #1;
    check("t5_gnt0", 32'(o_gnt), 32'b0001);
    check("t5_b1", 32'(o_data), 1);
    cyc(); d[0] = 10'd2; #1;
    check("t5_b2", 32'(o_data), 2);
`ifdef VERYL_TESTCASE_ARB_HOLD_LIMIT_EN
    cyc(); d[0] = 10'd3; #1;
    check("t5_hold_rel", 32'(o_busy), 0);
    cyc(); #1;
    check("t5_gnt1", 32'(o_gnt), 32'b0010);
    check("t5_d1", 32'(o_data), 32'h211);
    cyc(); #1;
    check("t5_idle2", 32'(o_busy), 0);
    cyc(); #1;
    check("t5_regnt0", 32'(o_gnt), 32'b0001);
    check("t5_b3", 32'(o_data), 3);
`else
    cyc(); d[0] = 10'd3; #1;
    check("t5_b3", 32'(o_data), 3);
    check("t5_own3", 32'(o_gnt), 32'b0001);
    cyc(); d[0] = 10'd4; #1;
    check("t5_b4", 32'(o_data), 4);
    cyc(); d[0] = 10'd5; i_last = 4'b0011; #1;
    check("t5_b5", 32'(o_data), 5);
    check("t5_l5", 32'(o_last), 1);
    cyc(); i_req = 4'b0010; #1;
    check("t5_rel", 32'(o_busy), 0);
    cyc(); #1;
    check("t5_gnt1", 32'(o_gnt), 32'b0010);
`endif

    // Asynchronous reset mid-burst.
    do_reset();
    i_req = 4'b0001; i_last = 4'b0000; i_ready = 1'b1; d[0] = 10'h155;
    cyc(); #1;
    check("t6_valid", 32'(o_valid), 1);
    cyc();
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_gnt", 32'(o_gnt), 0);
    check("t6_rst_busy", 32'(o_busy), 0);
    check("t6_rst_valid", 32'(o_valid), 0);
    check("t6_rst_data", 32'(o_data), 0);
    check("t6_rst_owner", 32'(o_owner), 0);
    cyc();
    i_rst_n = 1'b1; i_req = 4'b0011;
    cyc(); #1;
    check("t6_first_gnt", 32'(o_gnt), 32'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/veryl_testcase_module04_arbiter.md
# veryl_testcase_module04_arbiter

Round-robin arbiter and burst sequencer that shares one 10-bit datapath port among `N` requesters. Each requester presents a valid/last-tagged data stream. The arbiter grants one owner at a time, forwards that owner's beats to the shared sink with a valid/ready handshake, and releases the grant at end of burst. It sits in front of a shared 10-bit module input and is the only driver of that input.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `WIDTH`, default 10: data width per beat.
- `MAX_HOLD`, default 8: maximum accepted beats per grant, 1..255. Used only when the hold limit is compiled in.
- `i_clk`  input  1  clock; all state changes on the rising edge.
- `i_rst_n`  input  1  asynchronous, active-low reset.
- `i_req`  input  N  per-requester valid; bit k means requester k has a beat on `i_data[k]`.
- `i_data`  input  N x WIDTH  per-requester beat data.
- `i_last`  input  N  per-requester end-of-burst marker, qualified by `i_req[k]`.
- `o_gnt`  output  N  registered one-hot grant; all zero when idle.
- `o_owner`  output  $clog2(N)  registered index of the current owner.
- `o_busy`  output  1  registered; high while in BUSY.
- `o_valid`  output  1  shared-port valid: `o_busy & i_req[o_owner]`.
- `o_data`  output  WIDTH  `i_data[o_owner]` while busy, otherwise 0.
- `o_last`  output  1  `o_valid & i_last[o_owner]`.
- `i_ready`  input  1  shared-sink ready.

## Operation
- Two states:
  - IDLE: no owner.
  - BUSY: one owner holds the port.
- Round-robin pointer `ptr` holds the index of the last owner. Its reset value is N-1, so requester 0 has top priority after reset.
- IDLE, with any `i_req` bit set: choose the first set bit searching from `ptr+1` with wrap-around at N-1 to 0. Next cycle: `o_gnt` is one-hot at that index, `o_owner` equals the index, `o_busy` is 1, state is BUSY.
- IDLE, with no request: remain in IDLE; outputs hold at zero.
- BUSY: a beat is accepted on a cycle with `o_valid & i_ready`.
- BUSY release conditions, evaluated each cycle:
  - Accepted beat with `i_last[owner]`.
  - `i_req[owner]` low, meaning the requester withdraws. The release takes priority because no beat is transferred that cycle.
  - Hold limit reached (only when enabled).
- On release: next cycle is IDLE, `o_gnt` is 0, `o_busy` is 0, `ptr` is the owner.
- At most one idle cycle separates grants. Arbitration happens only in IDLE, so two owners never overlap.
- Non-owner requests are ignored while BUSY. Non-owners must hold `i_req` until granted.
- While BUSY, the owner may change `i_data` or `i_last` only after an accepted beat.
- `o_valid`, `o_data` and `o_last` are combinational from the owner's inputs. `o_gnt`, `o_owner`, `o_busy`, `ptr` and the beat counter are registered.

## Timing
- Request to grant: 1 cycle. `i_req[k]` is sampled high in IDLE at edge t, and `o_gnt[k]` is high after edge t.
- First beat can be accepted in the first BUSY cycle.
- Release takes effect at the edge that samples the release condition.
- Minimum grant-to-grant period: 2 cycles, from a one-beat burst followed by 1 IDLE cycle.
- Reset values: `o_gnt`=0, `o_owner`=0, `o_busy`=0, `o_valid`=0, `o_data`=0, `o_last`=0, state=IDLE, `ptr`=N-1, beat counter=0.
- Asserting reset mid-burst aborts the burst immediately and asynchronously. The in-flight beat is dropped and outputs go to their reset values.
- `i_ready` low while BUSY: the owner holds the port indefinitely. No timeout exists except the hold limit, which counts accepted beats only.

## Configuration
- `VERYL_TESTCASE_ARB_HOLD_LIMIT_EN` defined:
  - An 8-bit beat counter clears on grant and increments on each accepted beat.
  - When a beat is accepted with counter == MAX_HOLD-1, the arbiter releases even if `i_last` is low.
  - The requester re-arbitrates in round-robin order for the remainder of its burst.
  - `o_last` is not forced high on a forced release.
- Macro undefined: no counter is built. A grant lasts until `i_last` is accepted or the request is withdrawn. `MAX_HOLD` is ignored.

## Test plan
- Reset, then `i_req`=4'b0101 held, each requester sending 1-beat bursts with `i_ready`=1. Required: grants alternate 0, 2, 0, 2, each preceded by 1 IDLE cycle; `o_gnt` is never 4'b0101.
- `i_req`=4'b1111 with single-beat bursts. Required: grant order 0, 1, 2, 3, 0; grant k follows 2 cycles after grant k-1.
- Requester 1 bursts 3 beats (data 10'h001, 10'h002, 10'h3FF with last); `i_ready` toggles 1, 0, 1, 1, 0, 1. Required: `o_data` sequence accepted exactly 001, 002, 3FF; release after the third accepted beat.
- Owner 2 drops `i_req` mid-burst after 1 accepted beat. Required: `o_busy` goes to 0 next cycle; `ptr`=2; pending requester 3 is granted the following cycle.
- With the macro defined and MAX_HOLD=2, requester 0 sends a 5-beat burst while requester 1 is pending. Required: ownership sequence is 0 (2 beats), 1, then 0 resumes. Without the macro: all 5 beats go to requester 0 before requester 1 is granted.
- Assert `i_rst_n`=0 during BUSY with `o_valid`=1. Required: all outputs are 0 immediately, without waiting for a clock edge. After release, requester 0 wins first.
